// File: rtl/t07_spi_octal_pkg.sv
// Shared definitions for the octal-SPI link to the ESP32 (tx and rx directions).
// T07_SPI_TX_CRC_EN adds the trailing XOR check-byte state to the tx FSM.
package t07_spi_octal_pkg;

    localparam int ADDR_W         = 5;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [ADDR_W-1:0] MIN_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(31);

`ifdef T07_SPI_TX_CRC_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, CRC} t07_spi_tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND} t07_spi_tx_state_t;
`endif

    // Register addresses run 1..31; address 0 is reserved and never produced.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a >= MAX_ADDR) ? MIN_ADDR : a + 1'b1;
    endfunction

endpackage

// File: rtl/t07_octal_xor_acc.sv
// 8-bit XOR accumulator for the octal tx check byte; clr has priority over en.
module t07_octal_xor_acc
    import t07_spi_octal_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] acc
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc ^ d;
    end

endmodule

// File: rtl/t07_spi_octal_tx.sv
// Octal-SPI transmitter: reads words 1..31 from the register file and streams them MSB byte first.
// Optional T07_SPI_TX_CRC_EN appends one XOR check byte after the last data byte.
module t07_spi_octal_tx #(
    parameter int ADDR_W         = 5,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic              esp_hold,
    output logic [7:0]        esp_data,
    output logic              esp_cs_n,
    output logic              esp_valid,
    output logic              busy,
    output logic              done
);
    import t07_spi_octal_pkg::*;

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [1:0] PF_BYTE   = 2'(BYTES_PER_WORD - 2);

    t07_spi_tx_state_t state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] words_left;
    logic [31:0]       shreg;
    logic [31:0]       prefetch;
    logic [1:0]        byte_cnt;
    logic              pf_req;
    logic              in_frame;
    logic              step;
    logic              pf_issue;
    logic              accept;

`ifdef T07_SPI_TX_CRC_EN
    logic [BYTE_W-1:0] crc_byte;
    assign in_frame = (state == SEND) || (state == CRC);
`else
    assign in_frame = (state == SEND);
`endif

    assign accept   = (state == IDLE) && start && (word_count != '0);
    assign step     = in_frame && !esp_hold;
    assign pf_issue = (state == SEND) && (byte_cnt == PF_BYTE) && !esp_hold && (words_left != '0);

    assign rd_en     = (state == FETCH) || pf_issue;
    assign rd_addr   = (state == FETCH) ? addr : (pf_issue ? next_addr(addr) : '0);
    assign esp_cs_n  = !in_frame;
    assign esp_valid = step;
    assign busy      = (state != IDLE);

    always_comb begin
        esp_data = '0;
        if (state == SEND)
            esp_data = shreg[31:24];
`ifdef T07_SPI_TX_CRC_EN
        else if (state == CRC)
            esp_data = crc_byte;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = SEND;
            SEND: begin
                if (!esp_hold && byte_cnt == LAST_BYTE && words_left == '0) begin
`ifdef T07_SPI_TX_CRC_EN
                    state_nxt = CRC;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef T07_SPI_TX_CRC_EN
            CRC:   if (!esp_hold) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr       <= '0;
            words_left <= '0;
            shreg      <= '0;
            prefetch   <= '0;
            byte_cnt   <= '0;
            pf_req     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= in_frame && (state_nxt == IDLE);
            pf_req <= pf_issue;
            // Read data arrives one cycle after the strobe, whether or not the bus is held.
            if (pf_req)
                prefetch <= rd_data;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr       <= (start_addr == '0) ? MIN_ADDR : start_addr;
                        words_left <= word_count - 1'b1;
                    end
                end
                LOAD: begin
                    shreg    <= rd_data;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (!esp_hold) begin
                        if (byte_cnt == LAST_BYTE) begin
                            if (words_left != '0) begin
                                // Bypass when the prefetch lands on the same edge as the word switch.
                                shreg      <= pf_req ? rd_data : prefetch;
                                byte_cnt   <= '0;
                                addr       <= next_addr(addr);
                                words_left <= words_left - 1'b1;
                            end
                        end else begin
                            shreg    <= {shreg[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef T07_SPI_TX_CRC_EN
    t07_octal_xor_acc u_crc (
        .clk  (clk),
        .nrst (nrst),
        .clr  (state == IDLE),
        .en   (step && (state == SEND)),
        .d    (shreg[31:24]),
        .acc  (crc_byte)
    );
`endif

endmodule

// File: doc/t07_spi_octal_tx.md
# t07_spi_octal_tx

Octal-SPI transmitter toward the ESP32: the counterpart of the ESP32-to-chip octal receive path. On a start request it reads a run of 32-bit words from the external register file at addresses 1..31, then serialises each word MSB-byte-first onto an 8-bit parallel bus framed by an active-low chip select. It sits between the team's register file and the ESP32 pads, using the same byte order and the same 1..31 address convention as the receive direction.

## Interface
Parameters:
- ADDR_W, 5, register address width; usable addresses 1..31, address 0 reserved.
- BYTES_PER_WORD, 4, bytes per 32-bit word; fixed, not to be overridden.

Ports:
- clk  in  1  system clock; also the octal bus clock.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  5  first register address; 0 is treated as 1.
- word_count  in  5  words to send, 1..31; 0 means the request is ignored.
- rd_en  out  1  register-file read strobe, one cycle per word.
- rd_addr  out  5  read address, valid while rd_en=1.
- rd_data  in  32  read data, valid exactly one cycle after rd_en.
- esp_hold  in  1  ESP32 back-pressure; freezes the byte stream while high.
- esp_data  out  8  current byte.
- esp_cs_n  out  1  frame select, low for the whole frame.
- esp_valid  out  1  esp_data is consumed this cycle: esp_cs_n low and esp_hold low.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the frame ends.

## Operation
- FSM states: IDLE, FETCH, LOAD, SEND, CRC (CRC only when the macro is defined).
- IDLE: esp_cs_n=1, esp_data=0, rd_en=0. A start with word_count!=0 latches the address (0 becomes 1) and the count, then moves to FETCH.
- FETCH: rd_en=1, rd_addr=current address, then moves to LOAD.
- LOAD: captures rd_data into the shift register, clears byte_cnt, then moves to SEND.
- SEND: esp_cs_n=0 and esp_data=shreg[31:23-0 upper byte, i.e. shreg[31:24]].
  - On each cycle with esp_hold=0: shift the register left by 8 and increment byte_cnt.
  - When byte_cnt==2 and esp_hold=0 and words remain: issue rd_en for the next address. Capture the returned rd_data into a prefetch register on the following cycle, independent of esp_hold.
  - At byte 3 with esp_hold=0: if words remain, load the prefetch register and reset byte_cnt, so there is no gap between words. Otherwise go to CRC (macro defined) or to IDLE.
- Address increment: address+1, with 31 wrapping to 1. Address 0 is never driven.
- esp_hold high in any SEND or CRC cycle freezes esp_data, byte_cnt, the shift register and the address. esp_cs_n stays low.
- A start that arrives while busy is ignored.
- done is asserted in the first IDLE cycle. A start in that same cycle is accepted.
- Reset at any point, including mid-frame: immediately IDLE, esp_cs_n=1, and all outputs 0 except esp_cs_n.

## Timing
- Reset values: esp_cs_n=1; esp_data=0; esp_valid=0; rd_en=0; rd_addr=0; busy=0; done=0.
- All outputs are driven from flops or from state decode. No clock gating: esp_valid qualifies bytes and the pad logic uses clk.
- Start accepted at edge 0:
  - cycle 1: FETCH.
  - cycle 2: LOAD.
  - cycle 3: first byte, esp_cs_n falls.
- With no hold, N words occupy 4N consecutive esp_valid cycles. esp_cs_n rises and done pulses at cycle 3+4N, or 4+4N with CRC.
- Each cycle of hold extends the frame by one cycle.

## Configuration
- T07_SPI_TX_CRC_EN defined:
  - XOR-accumulate every byte sent with esp_valid=1.
  - After the last word, send one extra byte (the accumulator) in state CRC, still with esp_cs_n=0.
  - Clear the accumulator in IDLE.
- T07_SPI_TX_CRC_EN undefined: the CRC state and accumulator are absent, and the frame ends after the last data byte.

## Structure
- Package t07_spi_octal_pkg holds:
  - the state enum t07_spi_tx_state_t;
  - ADDR_W, BYTE_W=8, BYTES_PER_WORD=4;
  - MIN_ADDR=1, MAX_ADDR=31.
- The receive-direction block can share this package.
- One sub-module, t07_octal_xor_acc: an 8-bit XOR accumulator with clr and en inputs. It is instantiated only under T07_SPI_TX_CRC_EN.

## Test plan
- start_addr=5, word_count=1, rd_data=0xA1B2C3D4 -> rd_addr=5 in cycle 1; esp_data A1, B2, C3, D4 in cycles 3-6; esp_cs_n high and done in cycle 7.
- start_addr=30, word_count=3 -> reads at 30, 31, 1. Exactly 12 contiguous esp_valid cycles with no inter-word gap.
- esp_hold high for 3 cycles during byte 3 of word 1, with word_count=2 -> byte held stable, the prefetched word is not lost, and the frame is 3 cycles longer.
- word_count=0, and separately start while busy -> no rd_en, no state change, and the running frame is unaffected.
- nrst asserted mid-frame at byte 2 -> esp_cs_n=1 and busy=0 at once. A start after release sends a clean frame.
- T07_SPI_TX_CRC_EN, word 0x01020304 -> fifth byte 0x04 (01^02^03^04), then done.
